// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV32I instruction-fetch front end.
package fetch_pkg;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam int unsigned PC_STEP          = 4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_redirect_unit.sv
// Fetch front end: PC, single outstanding imem request, decode handshake, branch redirect/squash.
// Optional FETCH_REDIRECT_CNT_EN adds redirect_cnt / squash_cnt event counters.
module fetch_redirect_unit
  import fetch_pkg::*;
#(
  parameter int unsigned          XLEN     = 32,
  parameter logic [XLEN-1:0]      RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            br_valid,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_target,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc
`ifdef FETCH_REDIRECT_CNT_EN
  ,
  output logic [31:0]     redirect_cnt,
  output logic [31:0]     squash_cnt
`endif
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] ipc_q, ipc_d;
  logic            kill_q, kill_d;
  logic            live_q;

  logic            redirect;
  logic            req_fire;
  logic [XLEN-1:0] target;

  assign redirect = br_valid & br_taken;
  assign target   = br_target & ~XLEN'(3);
  assign req_fire = imem_req_valid & imem_req_ready;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= REQ;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      ipc_q   <= RESET_PC;
      kill_q  <= 1'b0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      kill_q  <= kill_d;
      live_q  <= 1'b1;
    end
  end

  // NOTE: every comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    kill_d  = kill_q;
    case (state_q)
      REQ: begin
        if (req_fire) begin
          state_d = WAIT;
          kill_d  = redirect;
        end
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          if (kill_q || redirect) begin
            kill_d  = 1'b0;
            state_d = REQ;
          end else begin
            instr_d = imem_rsp_data;
            ipc_d   = pc_q;
            pc_d    = pc_q + XLEN'(PC_STEP);
            state_d = HOLD;
          end
        end else if (redirect) begin
          kill_d = 1'b1;
        end
      end
      HOLD: begin
        if (redirect || if_ready) state_d = REQ;
      end
      default: state_d = REQ;
    endcase
    // A redirect overrides any sequential PC update above.
    if (redirect) pc_d = target;
  end

  always_comb begin
    imem_req_valid = live_q && (state_q == REQ);
    imem_req_addr  = pc_q;
    if_valid       = (state_q == HOLD);
    if_instr       = instr_q;
    if_pc          = ipc_q;
  end

`ifdef FETCH_REDIRECT_CNT_EN
  logic        discard;
  logic [31:0] redirect_cnt_q, squash_cnt_q;

  assign discard = (state_q == WAIT) && imem_rsp_valid && (kill_q || redirect);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_cnt_q <= '0;
      squash_cnt_q   <= '0;
    end else begin
      if (redirect) redirect_cnt_q <= redirect_cnt_q + 32'd1;
      if (discard)  squash_cnt_q   <= squash_cnt_q + 32'd1;
    end
  end

  assign redirect_cnt = redirect_cnt_q;
  assign squash_cnt   = squash_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Bench for fetch_redirect_unit: directed scenarios plus random traffic against a transaction-level model.
`timescale 1ns/1ps
module tb_fetch_redirect_unit;
  import fetch_pkg::*;

  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        br_valid, br_taken;
  logic [31:0] br_target;
  logic        if_valid, if_ready;
  logic [31:0] if_instr, if_pc;
`ifdef FETCH_REDIRECT_CNT_EN
  logic [31:0] redirect_cnt, squash_cnt;
`endif

  always #5 clk = ~clk;

  fetch_redirect_unit #(.XLEN(32), .RESET_PC(RPC)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .br_valid(br_valid), .br_taken(br_taken), .br_target(br_target),
    .if_valid(if_valid), .if_ready(if_ready),
    .if_instr(if_instr), .if_pc(if_pc)
`ifdef FETCH_REDIRECT_CNT_EN
    , .redirect_cnt(redirect_cnt), .squash_cnt(squash_cnt)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  // Transaction-level model: expected fetch address, the one outstanding fetch,
  // and the instruction currently offered to decode.
  logic [31:0] m_pc, m_out_addr, m_pend_pc, m_pend_instr, m_red_cnt, m_sq_cnt;
  bit          m_live, m_busy, m_stale, m_pend;

  task automatic model_reset();
    m_pc = RPC; m_out_addr = RPC; m_pend_pc = RPC; m_pend_instr = NOP_INSTR;
    m_red_cnt = 0; m_sq_cnt = 0;
    m_live = 0; m_busy = 0; m_stale = 0; m_pend = 0;
  endtask

  task automatic drive_idle();
    imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = 0;
    br_valid = 0; br_taken = 0; br_target = 0; if_ready = 0;
  endtask

  // One clock cycle, entered and left at a falling edge: compare outputs with the
  // model, drive inputs, advance the model across the rising edge.
  task automatic step(input bit brv, input bit brt, input logic [31:0] tgt,
                      input bit ifr, input bit mrdy, input bit rspv, input logic [31:0] rspd);
    bit exp_req, red, acc;
    exp_req = m_live && !m_busy && !m_pend;
    n_cmp++;
    if (imem_req_valid !== exp_req) begin
      n_err++; $display("FAIL req_valid: got %b expected %b at %0t", imem_req_valid, exp_req, $time);
    end
    if (exp_req) begin
      n_cmp++;
      if (imem_req_addr !== m_pc) begin
        n_err++; $display("FAIL req_addr: got %h expected %h at %0t", imem_req_addr, m_pc, $time);
      end
    end
    n_cmp++;
    if (if_valid !== m_pend) begin
      n_err++; $display("FAIL if_valid: got %b expected %b at %0t", if_valid, m_pend, $time);
    end
    if (m_pend) begin
      n_cmp++;
      if (if_pc !== m_pend_pc || if_instr !== m_pend_instr) begin
        n_err++; $display("FAIL if_data: got pc %h instr %h expected pc %h instr %h at %0t",
                          if_pc, if_instr, m_pend_pc, m_pend_instr, $time);
      end
    end
`ifdef FETCH_REDIRECT_CNT_EN
    n_cmp++;
    if (redirect_cnt !== m_red_cnt || squash_cnt !== m_sq_cnt) begin
      n_err++; $display("FAIL counters: got %0d/%0d expected %0d/%0d at %0t",
                        redirect_cnt, squash_cnt, m_red_cnt, m_sq_cnt, $time);
    end
`endif
    br_valid = brv; br_taken = brt; br_target = tgt; if_ready = ifr;
    imem_req_ready = mrdy; imem_rsp_valid = rspv && m_busy; imem_rsp_data = rspd;

    red = brv && brt;
    acc = exp_req && mrdy;
    if (m_pend && (red || ifr)) m_pend = 0;
    if (m_busy && rspv) begin
      if (m_stale || red) m_sq_cnt++;
      else begin
        m_pend = 1; m_pend_pc = m_out_addr; m_pend_instr = rspd; m_pc = m_out_addr + 32'd4;
      end
      m_busy = 0;
    end
    if (acc) begin m_busy = 1; m_out_addr = m_pc; m_stale = 0; end
    if (red) begin
      m_pc = tgt & ~32'h3; m_red_cnt++;
      if (m_busy) m_stale = 1;
    end
    m_live = 1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    drive_idle();
    rst_n = 0;
    repeat (2) @(negedge clk);
    n_cmp++; if (imem_req_valid !== 1'b0) begin n_err++; $display("FAIL rst_req_valid: got %b expected 0", imem_req_valid); end
    n_cmp++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL rst_if_valid: got %b expected 0", if_valid); end
    n_cmp++; if (if_instr !== NOP_INSTR) begin n_err++; $display("FAIL rst_if_instr: got %h expected %h", if_instr, NOP_INSTR); end
    n_cmp++; if (if_pc !== RPC) begin n_err++; $display("FAIL rst_if_pc: got %h expected %h", if_pc, RPC); end
    model_reset();
    rst_n = 1;
  endtask

  task automatic test_first_fetch();
    step(0, 0, 0, 1, 1, 0, 0);
    n_cmp++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
      n_err++; $display("FAIL first_req: got valid %b addr %h expected 1 / 00000000", imem_req_valid, imem_req_addr);
    end
    step(0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 1, 32'h0050_0093);
    n_cmp++;
    if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instr !== 32'h0050_0093) begin
      n_err++; $display("FAIL first_instr: got v %b pc %h instr %h expected 1 / 00000000 / 00500093", if_valid, if_pc, if_instr);
    end
  endtask

  task automatic test_stall();
    repeat (5) step(0, 0, 0, 0, 1, 0, 0);
    n_cmp++;
    if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instr !== 32'h0050_0093 || imem_req_valid !== 1'b0) begin
      n_err++; $display("FAIL stall_hold: got v %b pc %h instr %h req %b", if_valid, if_pc, if_instr, imem_req_valid);
    end
    step(0, 0, 0, 1, 1, 0, 0);
    n_cmp++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h4) begin
      n_err++; $display("FAIL next_req: got valid %b addr %h expected 1 / 00000004", imem_req_valid, imem_req_addr);
    end
  endtask

  task automatic test_redirect_wait();
    step(0, 0, 0, 1, 1, 0, 0);
    step(0, 0, 0, 1, 1, 1, 32'h00a0_0113);
    step(0, 0, 0, 1, 1, 0, 0);
    step(0, 0, 0, 1, 1, 0, 0);
    step(1, 1, 32'h0000_0100, 1, 1, 0, 0);
    step(0, 0, 0, 1, 1, 1, 32'hdead_beef);
    n_cmp++;
    if (if_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin
      n_err++; $display("FAIL redirect_wait: got v %b req %b addr %h expected 0 / 1 / 00000100", if_valid, imem_req_valid, imem_req_addr);
    end
  endtask

  task automatic test_redirect_hold();
    step(0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1, 1, 32'h1234_5678);
    step(1, 1, 32'h0000_0200, 0, 1, 0, 0);
    n_cmp++;
    if (if_valid !== 1'b0 || imem_req_addr !== 32'h200) begin
      n_err++; $display("FAIL redirect_hold: got v %b addr %h expected 0 / 00000200", if_valid, imem_req_addr);
    end
    step(0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1, 1, 32'h0011_2233);
    step(1, 0, 32'h0000_0300, 0, 1, 0, 0);
    n_cmp++;
    if (if_valid !== 1'b1 || if_pc !== 32'h200) begin
      n_err++; $display("FAIL not_taken: got v %b pc %h expected 1 / 00000200", if_valid, if_pc);
    end
    step(0, 0, 0, 1, 1, 0, 0);
    n_cmp++;
    if (imem_req_addr !== 32'h204) begin
      n_err++; $display("FAIL not_taken_next: got %h expected 00000204", imem_req_addr);
    end
  endtask

  task automatic test_misaligned_wrap();
    step(1, 1, 32'h0000_0103, 1, 0, 0, 0);
    n_cmp++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin
      n_err++; $display("FAIL misaligned: got valid %b addr %h expected 1 / 00000100", imem_req_valid, imem_req_addr);
    end
    step(1, 1, 32'hFFFF_FFFC, 1, 0, 0, 0);
    step(0, 0, 0, 1, 1, 0, 0);
    step(0, 0, 0, 0, 1, 1, 32'h0000_0073);
    n_cmp++;
    if (if_pc !== 32'hFFFF_FFFC) begin
      n_err++; $display("FAIL top_pc: got %h expected fffffffc", if_pc);
    end
    step(0, 0, 0, 1, 1, 0, 0);
    n_cmp++;
    if (imem_req_addr !== 32'h0) begin
      n_err++; $display("FAIL pc_wrap: got %h expected 00000000", imem_req_addr);
    end
    // Redirect in the same cycle the request is accepted: that fetch is squashed.
    step(1, 1, 32'h0000_0040, 1, 1, 0, 0);
    step(0, 0, 0, 1, 1, 1, 32'hbad0_0bad);
    n_cmp++;
    if (if_valid !== 1'b0 || imem_req_addr !== 32'h40) begin
      n_err++; $display("FAIL redirect_req_acc: got v %b addr %h expected 0 / 00000040", if_valid, imem_req_addr);
    end
  endtask

  task automatic test_async_reset();
    step(0, 0, 0, 1, 1, 0, 0);
    step(0, 0, 0, 1, 1, 1, 32'h0040_0513);
    step(0, 0, 0, 1, 1, 0, 0);
    step(0, 0, 0, 1, 1, 0, 0);
    #2 rst_n = 0;
    #1;
    n_cmp++; if (imem_req_valid !== 1'b0) begin n_err++; $display("FAIL async_req_valid: got %b expected 0", imem_req_valid); end
    n_cmp++; if (if_pc !== RPC) begin n_err++; $display("FAIL async_if_pc: got %h expected %h", if_pc, RPC); end
    n_cmp++; if (if_instr !== NOP_INSTR) begin n_err++; $display("FAIL async_if_instr: got %h expected %h", if_instr, NOP_INSTR); end
    drive_idle();
    model_reset();
    @(negedge clk);
    rst_n = 1;
  endtask

`ifdef FETCH_REDIRECT_CNT_EN
  task automatic test_counters();
    step(1, 1, 32'h0000_0010, 1, 0, 0, 0);
    step(0, 0, 0, 1, 1, 0, 0);
    step(1, 1, 32'h0000_0020, 1, 1, 0, 0);
    step(1, 1, 32'h0000_0030, 1, 1, 1, 32'h1);
    n_cmp++;
    if (redirect_cnt !== 32'd3) begin
      n_err++; $display("FAIL redirect_cnt3: got %0d expected 3", redirect_cnt);
    end
  endtask
`endif

  task automatic test_random(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      logic [31:0] tgt;
      tgt = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : $urandom;
      step($urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1, tgt,
           $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 2) != 0, $urandom);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_first_fetch();
    test_stall();
    test_redirect_wait();
    test_redirect_hold();
    test_misaligned_wrap();
    test_async_reset();
`ifdef FETCH_REDIRECT_CNT_EN
    test_counters();
`endif
    test_random(3000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_redirect_unit.md
Name: fetch_redirect_unit

Overview:
- Instruction-fetch front end of the RV32I core; the consumer end of the Branch unit's resolution output.
- Holds the PC and issues one outstanding word request to instruction memory.
- Presents fetched instructions downstream with valid/ready.
- Accepts branch resolutions (taken + target), redirects the PC and squashes wrong-path fetches.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset
- XLEN, 32, address/data width (only 32 supported)

Ports:
- clk  input  1  core clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- imem_req_valid  output  1  fetch request valid
- imem_req_ready  input  1  memory accepts request this cycle
- imem_req_addr  output  XLEN  word-aligned fetch address
- imem_rsp_valid  input  1  response data valid; exactly one per accepted request
- imem_rsp_data  input  XLEN  instruction word
- br_valid  input  1  branch resolution strobe from Branch unit (en)
- br_taken  input  1  branch outcome (res)
- br_target  input  XLEN  redirect target
- if_valid  output  1  instruction available to decode
- if_ready  input  1  decode accepts instruction
- if_instr  output  XLEN  instruction word
- if_pc  output  XLEN  PC of if_instr

Behaviour:
- Reset (rst_n=0, async):
  - pc=RESET_PC, state=REQ, kill=0.
  - Outputs: if_valid=0, if_instr=32'h0000_0013 (NOP), if_pc=RESET_PC, imem_req_valid=0 while rst_n low.
- Redirect = br_valid & br_taken. br_valid & !br_taken has no effect.
- Redirect target: pc <= {br_target[31:2],2'b00}.
- FSM states: REQ, WAIT, HOLD.
- REQ:
  - imem_req_valid=1, imem_req_addr=pc.
  - On imem_req_ready -> WAIT.
  - imem_req_addr may change while not yet accepted, but only on a redirect.
- WAIT:
  - imem_req_valid=0. On imem_rsp_valid:
    - If kill or redirect this cycle: discard data, clear kill, -> REQ.
    - Else: if_instr<=data, if_pc<=pc, pc<=pc+4, if_valid<=1 -> HOLD.
- HOLD:
  - if_valid=1; outputs held stable until if_ready.
  - On if_ready & !redirect: if_valid<=0 -> REQ.
- Redirect, per state:
  - REQ, request accepted same cycle: the request goes out with the old address, kill<=1, pc<=target, -> WAIT.
  - REQ, not accepted: pc<=target, stay REQ; the new address is on imem_req_addr next cycle.
  - WAIT: kill<=1 (or discard immediately if rsp_valid is the same cycle), pc<=target.
  - HOLD: if_valid<=0 next cycle regardless of if_ready; pc<=target -> REQ.
  - Redirect takes priority over every other event.
- Latency: request issues 1 cycle after reset release. With zero-wait memory (ready=1, rsp the next cycle), if_valid rises 2 cycles after the request is issued.
- Back-to-back redirects: the last one wins; kill is a flag, not a counter (one request outstanding at most).
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 wraps to 0.
- Reset mid-operation: everything returns to reset values immediately. The memory system must drop any in-flight response.

Optional Feature:
- Macro: FETCH_REDIRECT_CNT_EN.
- When defined: adds output redirect_cnt [31:0].
  - Reset 0.
  - Increments by 1 on each cycle with a redirect; wraps at 2^32.
  - Counts squashed fetches via kill/discard separately in squash_cnt [31:0].
- When undefined: neither port nor the counter logic exists; behaviour is otherwise identical.

Decomposition:
- Shared package fetch_pkg:
  - fetch_state_t enum {REQ, WAIT, HOLD}
  - NOP_INSTR = 32'h0000_0013
  - PC_STEP = 4
  - RESET_PC default constant
- Sub-modules: none. Single module; the FSM, PC register and output register are small enough to keep together.

Test Plan:
- Reset release with RESET_PC=0, ready=1, rsp one cycle later with data 32'h00500093 -> req addr 0 at cycle 1; if_valid=1, if_pc=0, if_instr=32'h00500093; next request addr 4.
- Downstream stall: hold if_ready=0 for 5 cycles -> if_valid, if_instr, if_pc stable; no new imem request; released on if_ready=1.
- Redirect in WAIT: br_valid=1, br_taken=1, br_target=32'h0000_0100 while waiting on a request for addr 8 -> response discarded, if_valid stays 0, next request addr 32'h100.
- Redirect in HOLD with if_ready=0 -> if_valid drops next cycle, next request addr = target. Also br_taken=0 -> no change.
- Misaligned target 32'h0000_0103 -> request addr 32'h0000_0100. PC at 32'hFFFF_FFFC fetched -> next addr 0.
- Async reset asserted while in WAIT -> outputs return to reset values without a clock edge. With FETCH_REDIRECT_CNT_EN: 3 redirects -> redirect_cnt=3.
